// File: rtl/dct_ft.sv
// 8-point forward DCT over one row of 8-bit pixels, using a lifting-style
// butterfly network in 19-bit signed fixed point with 3 fractional bits.
module dct_ft #(
  parameter int OUT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [8*OUT_W-1:0]   m_data
);

  typedef enum logic [1:0] {COLLECT, CALC1, CALC2, HOLD} state_t;
  typedef logic signed [18:0] fx_t;

  localparam int MAXV = 2**(OUT_W-1) - 1;
  localparam int MINV = -(2**(OUT_W-1));

  state_t     state, state_nx;
  logic [2:0] cnt;
  logic [7:0] samp [8];
  fx_t        d    [8];
  fx_t        y    [8];
  fx_t        d_nx [8];
  fx_t        y_nx [8];
  logic       accept;

  // Round to a multiple of 8 (one integer unit), ties away from zero.
  function automatic fx_t rnd(input fx_t v);
    fx_t a;
    if (v < 0) begin
      a = -v;
      a = (a + 19'sd4) & 19'sh7FFF8;
      return -a;
    end else begin
      return (v + 19'sd4) & 19'sh7FFF8;
    end
  endfunction

  assign accept = s_valid && (state == COLLECT);

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    case (state)
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid && cnt == 3'd7) state_nx = CALC1;
      end
      CALC1: state_nx = CALC2;
      CALC2: state_nx = HOLD;
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_comb begin : calc1
    fx_t p [8];
    fx_t b [8];
    fx_t c [8];
    for (int unsigned i = 0; i < 8; i++) begin
      p[i] = (fx_t'({11'd0, samp[i]}) - fx_t'(128)) <<< 3;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      b[i]     = p[i] + p[7-i];
      b[7-i]   = p[i] - p[7-i];
    end
    for (int unsigned i = 0; i < 8; i++) c[i] = b[i];
    c[6] = b[6] + rnd((b[5] >>> 3) + (b[5] >>> 2));
    c[5] = rnd((c[6] >>> 3) + (c[6] >>> 1)) - b[5];
    d_nx[0] = c[0] + c[3];
    d_nx[3] = c[0] - c[3];
    d_nx[1] = c[1] + c[2];
    d_nx[2] = c[1] - c[2];
    d_nx[4] = c[4] + c[5];
    d_nx[5] = c[4] - c[5];
    d_nx[6] = c[7] - c[6];
    d_nx[7] = c[6] + c[7];
  end

  // y1/y3/y6 lift off y0/y2/y5 computed in the same cycle.
  always_comb begin : calc2
    y_nx[0] = d[0] + d[1];
    y_nx[1] = rnd(y_nx[0] >>> 1) - d[1];
    y_nx[2] = d[2] - rnd((d[3] >>> 3) + (d[3] >>> 2));
    y_nx[3] = d[3] + rnd((y_nx[2] >>> 3) + (y_nx[2] >>> 2));
    y_nx[7] = d[7];
    y_nx[4] = d[4] - rnd(d[7] >>> 3);
    y_nx[5] = d[5] + rnd((d[6] >>> 3) + (d[6] >>> 2) + (d[6] >>> 1));
    y_nx[6] = d[6] - rnd(y_nx[5] >>> 1);
  end

  always_comb begin : outsat
    fx_t sh;
    m_data = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      sh = y[k] >>> 3;
      if (int'(sh) > MAXV)      m_data[k*OUT_W +: OUT_W] = OUT_W'(MAXV);
      else if (int'(sh) < MINV) m_data[k*OUT_W +: OUT_W] = OUT_W'(MINV);
      else                      m_data[k*OUT_W +: OUT_W] = OUT_W'(sh);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      cnt   <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        samp[i] <= '0;
        d[i]    <= '0;
        y[i]    <= '0;
      end
    end else begin
      state <= state_nx;
      if (accept) begin
        samp[cnt] <= s_data;
        cnt       <= cnt + 3'd1;
      end
      if (state == CALC1) for (int unsigned i = 0; i < 8; i++) d[i] <= d_nx[i];
      if (state == CALC2) for (int unsigned i = 0; i < 8; i++) y[i] <= y_nx[i];
    end
  end

endmodule
